// File: rtl/led_scan_driver_pkg.sv
// Shared constants, state encoding and helpers for the LED column scan driver.
package led_scan_driver_pkg;

    localparam int         NUM_COLS = 8;
    localparam int         COL_W    = 3;
    localparam int         TIMER_W  = 20;
    localparam logic [7:0] COL_OFF  = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low one-hot column select for a given column index.
    function automatic logic [7:0] col_select(input logic [COL_W-1:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Dwell/blank interval counter: cleared by load, otherwise counts up every
// clock; done is high while the count sits on the terminal value.
module led_scan_timer
    import led_scan_driver_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Restart from zero on load or reset, otherwise advance by one.
    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = (count == terminal);

endmodule

// File: rtl/led_scan_driver.sv
// Column-multiplexed red/blue LED matrix driver with double-buffered frame
// memory. Buffer swaps are deferred to the column 7 -> 0 wrap so a frame is
// always drawn from a single buffer.
module led_scan_driver
    import led_scan_driver_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [7:0]       wr_red,
    input  logic [7:0]       wr_blue,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic [7:0]       column,
    output logic [7:0]       red,
    output logic [7:0]       blue,
    output logic [COL_W-1:0] col_idx,
    output logic             frame_done
);

    // The blank interval only needs the low 8 bits of the shared 20-bit timer.
    localparam logic [TIMER_W-1:0] DWELL_TERM = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BLANK_TERM = TIMER_W'(BLANK_CYCLES - 1);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [COL_W-1:0]   next_col;
    logic               wrap;
    logic               swap_now;
    logic               front_sel;
    logic               wr_bank;
    logic               timer_load;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_term;
    logic [7:0]         column_d;
    logic [7:0]         red_d;
    logic [7:0]         blue_d;

    logic [7:0] red_buf  [2][NUM_COLS];
    logic [7:0] blue_buf [2][NUM_COLS];

    assign timer_term = (state == BLANK) ? BLANK_TERM : DWELL_TERM;
    assign timer_load = !enable || timer_done;

    led_scan_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (CLK),
        .reset_n  (RESET_N),
        .load     (timer_load),
        .terminal (timer_term),
        .done     (timer_done)
    );

    // A swap request seen on the wrap cycle itself joins the wrap's swap.
    assign swap_now = wrap && (swap_pending || swap_req);
    // Writes on the swap cycle go to the buffer that becomes back afterwards.
    assign wr_bank  = swap_now ? front_sel : ~front_sel;

    // Next state and scan position: blank/drive alternation, column advance.
    always_comb begin
        next_state = state;
        next_col   = col_idx;
        wrap       = 1'b0;
        if (!enable) begin
            next_state = BLANK;
        end else if (timer_done) begin
            if (state == BLANK) begin
                next_state = DRIVE;
            end else begin
                next_state = BLANK;
                next_col   = col_idx + COL_W'(1);
                wrap       = (col_idx == COL_W'(NUM_COLS - 1));
            end
        end
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        column_d = COL_OFF;
        red_d    = '0;
        blue_d   = '0;
        if (next_state == DRIVE) begin
            column_d = col_select(next_col);
            red_d    = red_buf[front_sel][next_col];
            blue_d   = blue_buf[front_sel][next_col];
        end
    end

    // State register plus registered outputs and buffer selection.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state        <= BLANK;
            col_idx      <= '0;
            swap_pending <= 1'b0;
            frame_done   <= 1'b0;
            front_sel    <= 1'b0;
            column       <= COL_OFF;
            red          <= '0;
            blue         <= '0;
        end else begin
            state        <= next_state;
            col_idx      <= next_col;
            frame_done   <= wrap;
            swap_pending <= wrap ? 1'b0 : (swap_pending || swap_req);
            if (swap_now) begin
                front_sel <= ~front_sel;
            end
            column       <= column_d;
            red          <= red_d;
            blue         <= blue_d;
        end
    end

    // Frame memory: cleared on reset, host writes always target the back buffer.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    red_buf[b][c]  <= '0;
                    blue_buf[b][c] <= '0;
                end
            end
        end else if (wr_en) begin
            red_buf[wr_bank][wr_col]  <= wr_red;
            blue_buf[wr_bank][wr_col] <= wr_blue;
        end
    end

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver with DWELL_CYCLES=4, BLANK_CYCLES=2.
// Each column takes 6 clocks (2 blank + 4 drive), a frame takes 48 clocks.
// Expected values are hand-computed per cycle relative to the reset edge T0.
module tb_led_scan_driver;

    localparam int T0     = 3;
    localparam int S_COL  = 0;
    localparam int S_RED  = 1;
    localparam int S_BLUE = 2;
    localparam int S_IDX  = 3;
    localparam int S_PEND = 4;
    localparam int S_DONE = 5;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [7:0] wr_red;
    logic [7:0] wr_blue;
    logic       swap_req;
    logic       swap_pending;
    logic [7:0] column;
    logic [7:0] red;
    logic [7:0] blue;
    logic [2:0] col_idx;
    logic       frame_done;

    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    exp_t exp_q[$];
    exp_t cur;

    led_scan_driver #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_red       (wr_red),
        .wr_blue      (wr_blue),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .column       (column),
        .red          (red),
        .blue         (blue),
        .col_idx      (col_idx),
        .frame_done   (frame_done)
    );

    always #5 CLK = ~CLK;

    // Count rising edges; cyc == N means edge N has happened.
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] pick(input int sig);
        case (sig)
            S_COL:   return column;
            S_RED:   return red;
            S_BLUE:  return blue;
            S_IDX:   return {5'b0, col_idx};
            S_PEND:  return {7'b0, swap_pending};
            S_DONE:  return {7'b0, frame_done};
            default: return 8'h00;
        endcase
    endfunction

    // Queue an expectation, kept sorted by cycle.
    task automatic expect_at(input int rel, input int sig, input logic [7:0] val, input string name);
        exp_t e;
        int   pos;
        e.cyc  = T0 + rel;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        pos    = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > e.cyc) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endtask

    task automatic check_output(input exp_t e);
        logic [7:0] act;
        total++;
        if (e.cyc != cyc) begin
            $display("[TB] FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else begin
            act = pick(e.sig);
            if (act === e.val) begin
                passed++;
            end else begin
                $display("[TB] FAIL %s @%0d: got %h, expected %h", e.name, cyc, act, e.val);
            end
        end
    endtask

    // Monitor: pop and compare every expectation due in this cycle.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            check_output(cur);
        end
    end

    task automatic wait_cycle(input int rel);
        while (cyc < T0 + rel) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load_expectations();
        // Reset state and first columns with empty buffers
        expect_at(0, S_COL,  8'hFF, "reset_column");
        expect_at(0, S_RED,  8'h00, "reset_red");
        expect_at(0, S_BLUE, 8'h00, "reset_blue");
        expect_at(0, S_IDX,  8'h00, "reset_col_idx");
        expect_at(0, S_PEND, 8'h00, "reset_pending");
        expect_at(0, S_DONE, 8'h00, "reset_frame_done");
        expect_at(1, S_COL,  8'hFF, "blank_second");
        expect_at(2, S_COL,  8'hFE, "col0_first");
        expect_at(3, S_RED,  8'h00, "col0_red_zero");
        expect_at(5, S_COL,  8'hFE, "col0_last");
        expect_at(6, S_COL,  8'hFF, "blank_after_col0");
        expect_at(7, S_COL,  8'hFF, "blank2_after_col0");
        expect_at(8, S_COL,  8'hFD, "col1_first");
        expect_at(8, S_IDX,  8'h01, "col1_idx");
        // Back-buffer write and deferred swap
        expect_at(2,  S_PEND, 8'h00, "pend_before_req");
        expect_at(3,  S_PEND, 8'h01, "pend_set");
        expect_at(21, S_COL,  8'hF7, "f0_col3_select");
        expect_at(21, S_RED,  8'h00, "f0_back_write_hidden");
        expect_at(47, S_PEND, 8'h01, "pend_held");
        expect_at(47, S_DONE, 8'h00, "done_before_wrap");
        expect_at(48, S_PEND, 8'h00, "pend_clear_on_wrap");
        expect_at(48, S_DONE, 8'h01, "done_wrap1");
        expect_at(48, S_IDX,  8'h00, "idx_wrap1");
        expect_at(49, S_DONE, 8'h00, "done_one_cycle");
        expect_at(63, S_COL,  8'hFB, "f1_col2_select");
        expect_at(63, S_RED,  8'h00, "f1_col2_red");
        expect_at(69, S_COL,  8'hF7, "f1_col3_select");
        expect_at(69, S_RED,  8'hA5, "f1_col3_red");
        expect_at(69, S_BLUE, 8'h0F, "f1_col3_blue");
        expect_at(69, S_IDX,  8'h03, "f1_col3_idx");
        // Swap request on the wrap cycle itself
        expect_at(95,  S_PEND, 8'h00, "wrapreq_pend_before");
        expect_at(95,  S_DONE, 8'h00, "wrapreq_done_before");
        expect_at(96,  S_PEND, 8'h00, "wrapreq_pend_at_wrap");
        expect_at(96,  S_DONE, 8'h01, "wrapreq_done");
        expect_at(97,  S_PEND, 8'h00, "wrapreq_pend_after");
        expect_at(97,  S_DONE, 8'h00, "wrapreq_done_after");
        expect_at(117, S_COL,  8'hF7, "f2_col3_select");
        expect_at(117, S_RED,  8'h00, "f2_swapped_to_zero");
        expect_at(129, S_COL,  8'hDF, "f2_col5_select");
        expect_at(129, S_RED,  8'h00, "f2_swap_cycle_write_hidden");
        // Three requests in one frame give a single exchange
        expect_at(100, S_PEND, 8'h01, "multi_pend_set");
        expect_at(115, S_PEND, 8'h01, "multi_pend_mid");
        expect_at(143, S_PEND, 8'h01, "multi_pend_end");
        expect_at(144, S_PEND, 8'h00, "multi_pend_clear");
        expect_at(144, S_DONE, 8'h01, "done_wrap3");
        expect_at(165, S_RED,  8'hA5, "f3_col3_red");
        expect_at(177, S_COL,  8'hDF, "f3_col5_select");
        expect_at(177, S_RED,  8'h3C, "f3_col5_red");
        expect_at(177, S_BLUE, 8'hC3, "f3_col5_blue");
        expect_at(192, S_PEND, 8'h00, "no_second_swap_pend");
        expect_at(192, S_DONE, 8'h01, "done_wrap4");
        expect_at(213, S_RED,  8'hA5, "f4_col3_red_unchanged");
        expect_at(224, S_COL,  8'hDF, "f4_col5_select");
        expect_at(224, S_RED,  8'h3C, "f4_col5_red_unchanged");
        // Enable dropped while driving column 5
        expect_at(225, S_COL,  8'hFF, "disable_blank");
        expect_at(225, S_IDX,  8'h05, "disable_idx_hold");
        expect_at(225, S_RED,  8'h00, "disable_red_off");
        expect_at(228, S_COL,  8'hFF, "disabled_blank");
        expect_at(228, S_IDX,  8'h05, "disabled_idx_hold");
        expect_at(229, S_COL,  8'hFF, "reenable_blank2");
        expect_at(230, S_COL,  8'hDF, "reenable_col5");
        expect_at(230, S_RED,  8'h3C, "reenable_col5_red");
        expect_at(230, S_IDX,  8'h05, "reenable_col5_idx");
        expect_at(245, S_DONE, 8'h00, "done_before_wrap5");
        expect_at(246, S_DONE, 8'h01, "done_wrap5");
        expect_at(246, S_IDX,  8'h00, "idx_wrap5");
        // Reset mid-drive with a swap pending
        expect_at(250, S_PEND, 8'h01, "prereset_pend");
        expect_at(254, S_COL,  8'hFD, "prereset_col1");
        expect_at(254, S_PEND, 8'h01, "prereset_pend_held");
        expect_at(255, S_COL,  8'hFF, "midreset_column");
        expect_at(255, S_IDX,  8'h00, "midreset_idx");
        expect_at(255, S_PEND, 8'h00, "midreset_pend");
        expect_at(255, S_RED,  8'h00, "midreset_red");
        expect_at(255, S_DONE, 8'h00, "midreset_done");
        expect_at(276, S_COL,  8'hF7, "postreset_col3_select");
        expect_at(276, S_RED,  8'h00, "postreset_col3_red");
        expect_at(276, S_BLUE, 8'h00, "postreset_col3_blue");
        expect_at(288, S_COL,  8'hDF, "postreset_col5_select");
        expect_at(288, S_RED,  8'h00, "postreset_col5_red");
        expect_at(303, S_DONE, 8'h01, "postreset_wrap_done");
        expect_at(303, S_PEND, 8'h00, "postreset_no_swap");
    endtask

    task automatic apply_stimulus();
        RESET_N  = 1'b0;
        enable   = 1'b0;
        wr_en    = 1'b0;
        wr_col   = 3'd0;
        wr_red   = 8'h00;
        wr_blue  = 8'h00;
        swap_req = 1'b0;
        while (cyc < T0) begin
            @(posedge CLK);
            #1;
        end
        RESET_N = 1'b1;
        enable  = 1'b1;
        wait_cycle(1);
        wr_en = 1'b1; wr_col = 3'd3; wr_red = 8'hA5; wr_blue = 8'h0F;
        wait_cycle(2);
        wr_en = 1'b0; swap_req = 1'b1;
        wait_cycle(3);
        swap_req = 1'b0;
        wait_cycle(95);
        swap_req = 1'b1;
        wr_en = 1'b1; wr_col = 3'd5; wr_red = 8'h3C; wr_blue = 8'hC3;
        wait_cycle(96);
        swap_req = 1'b0; wr_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_cycle(99 + 10 * p);
            swap_req = 1'b1;
            wait_cycle(100 + 10 * p);
            swap_req = 1'b0;
        end
        wait_cycle(224);
        enable = 1'b0;
        wait_cycle(228);
        enable = 1'b1;
        wait_cycle(249);
        swap_req = 1'b1;
        wait_cycle(250);
        swap_req = 1'b0;
        wait_cycle(254);
        RESET_N = 1'b0;
        wait_cycle(255);
        RESET_N = 1'b1;
        wait_cycle(312);
    endtask

    initial begin
        load_expectations();
        apply_stimulus();
        @(negedge CLK);
        #1;
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            total++;
            $display("[TB] FAIL %s: never sampled, required %h at cycle %0d", cur.name, cur.val, cur.cyc);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
